// File: rtl/spi_flash_cmd_seq.sv
// Flash command sequencer: splits one opcode/address/write/read request into single
// bytes for the SPI byte driver, keeping exactly one byte in flight at a time.
module spi_flash_cmd_seq #(
  parameter int         P_LEN_W = 16,
  parameter logic [7:0] P_DUMMY = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_op_valid,
  output logic               o_op_ready,
  input  logic [7:0]         i_op_cmd,
  input  logic               i_op_has_addr,
  input  logic [23:0]        i_op_addr,
  input  logic [P_LEN_W-1:0] i_op_wr_len,
  input  logic [P_LEN_W-1:0] i_op_rd_len,
  input  logic [7:0]         i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  output logic [7:0]         o_drv_data,
  output logic               o_drv_valid,
  input  logic               i_drv_ready,
  input  logic [7:0]         i_drv_rdata,
  input  logic               i_drv_rvalid,
  output logic [7:0]         o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_DONE} state_t;

  localparam logic [P_LEN_W-1:0] LEN_ONE = P_LEN_W'(1);

  state_t               state, state_nxt;
  state_t               post_hdr, post_wr;
  logic                 wait_q;
  logic [7:0]           cmd_q;
  logic                 has_addr_q;
  logic [23:0]          addr_q;
  logic [P_LEN_W-1:0]   wr_len_q, rd_len_q;
  logic [P_LEN_W-1:0]   wr_cnt, rd_cnt;
  logic [1:0]           byte_idx;
  logic                 op_acc, drv_hs, byte_done;

  assign op_acc    = o_op_ready & i_op_valid;
  assign drv_hs    = o_drv_valid & i_drv_ready;
  // A completion only counts while a byte is actually in flight.
  assign byte_done = wait_q & i_drv_rvalid;

  assign post_wr  = (rd_len_q != '0) ? S_RDATA : S_DONE;
  assign post_hdr = (wr_len_q != '0) ? S_WDATA : post_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (op_acc) state_nxt = S_CMD;
      S_CMD:   if (byte_done) state_nxt = has_addr_q ? S_ADDR : post_hdr;
      S_ADDR:  if (byte_done && byte_idx == 2'd2) state_nxt = post_hdr;
      S_WDATA: if (byte_done && wr_cnt == LEN_ONE) state_nxt = post_wr;
      S_RDATA: if (byte_done && rd_cnt == LEN_ONE) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_op_ready  = 1'b0;
    o_drv_data  = 8'h00;
    o_drv_valid = 1'b0;
    o_wr_ready  = 1'b0;
    case (state)
      S_IDLE:  o_op_ready = 1'b1;
      S_CMD: begin
        o_drv_data  = cmd_q;
        o_drv_valid = !wait_q;
      end
      S_ADDR: begin
        case (byte_idx)
          2'd0:    o_drv_data = addr_q[23:16];
          2'd1:    o_drv_data = addr_q[15:8];
          default: o_drv_data = addr_q[7:0];
        endcase
        o_drv_valid = !wait_q;
      end
      S_WDATA: begin
        o_drv_data  = i_wr_data;
        o_drv_valid = i_wr_valid & !wait_q;
        o_wr_ready  = i_drv_ready & !wait_q;
      end
      S_RDATA: begin
        o_drv_data  = P_DUMMY;
        o_drv_valid = !wait_q;
      end
      default: ;
    endcase
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= 1'b0;
      cmd_q      <= 8'h00;
      has_addr_q <= 1'b0;
      addr_q     <= 24'h0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      byte_idx   <= 2'd0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= 8'h00;
    end else begin
      if (byte_done)   wait_q <= 1'b0;
      else if (drv_hs) wait_q <= 1'b1;

      if (op_acc) begin
        cmd_q      <= i_op_cmd;
        has_addr_q <= i_op_has_addr;
        addr_q     <= i_op_addr;
        wr_len_q   <= i_op_wr_len;
        rd_len_q   <= i_op_rd_len;
        wr_cnt     <= i_op_wr_len;
        rd_cnt     <= i_op_rd_len;
        byte_idx   <= 2'd0;
      end

      // Counters saturate at zero so a stray completion can never wrap them.
      if (byte_done) begin
        case (state)
          S_ADDR:  byte_idx <= byte_idx + 2'd1;
          S_WDATA: if (wr_cnt != '0) wr_cnt <= wr_cnt - LEN_ONE;
          S_RDATA: if (rd_cnt != '0) rd_cnt <= rd_cnt - LEN_ONE;
          default: ;
        endcase
      end

      o_rd_valid <= byte_done && (state == S_RDATA);
      if (byte_done && (state == S_RDATA)) o_rd_data <= i_drv_rdata;
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Bench for spi_flash_cmd_seq: a byte-driver model answers every handshake, and
// queued expectations check driver bytes and read data as they appear.
`timescale 1ns/1ps
module tb_spi_flash_cmd_seq;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_op_valid, o_op_ready;
  logic [7:0]    i_op_cmd;
  logic          i_op_has_addr;
  logic [23:0]   i_op_addr;
  logic [LW-1:0] i_op_wr_len, i_op_rd_len;
  logic [7:0]    i_wr_data;
  logic          i_wr_valid, o_wr_ready;
  logic [7:0]    o_drv_data;
  logic          o_drv_valid, i_drv_ready;
  logic [7:0]    i_drv_rdata;
  logic          i_drv_rvalid;
  logic [7:0]    o_rd_data;
  logic          o_rd_valid, o_busy, o_done;

  always #5 clk = ~clk;

  spi_flash_cmd_seq #(.P_LEN_W(LW), .P_DUMMY(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_op_cmd(i_op_cmd),
    .i_op_has_addr(i_op_has_addr), .i_op_addr(i_op_addr),
    .i_op_wr_len(i_op_wr_len), .i_op_rd_len(i_op_rd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_drv_data(o_drv_data), .o_drv_valid(o_drv_valid), .i_drv_ready(i_drv_ready),
    .i_drv_rdata(i_drv_rdata), .i_drv_rvalid(i_drv_rvalid),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0, fails = 0;
  logic [7:0] exp_drv[$], exp_rd[$], resp_q[$], wr_q[$];
  int  hs_cnt = 0, rd_cnt = 0, wr_hs = 0, done_cnt = 0, bp_checks = 0, bp_left = 0;
  bit  bp_armed = 0, spur = 0, busy_at_done = 0;
  logic [7:0] bp_byte = 8'h00;
  time t_done = 0;

  // Driver/user model: drives at the falling edge, samples 1ns before the rising edge.
  initial begin : drv_model
    int lat, gap;
    bit wr_taken;
    logic [7:0] pend, e;
    lat = -1; gap = 0; wr_taken = 0; pend = 8'h00; e = 8'h00;
    i_drv_ready = 1'b1; i_drv_rvalid = 1'b0; i_drv_rdata = 8'h00;
    i_wr_valid = 1'b0; i_wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        i_drv_rvalid = 1'b0;
        if (spur) begin
          i_drv_rvalid = 1'b1; i_drv_rdata = 8'h77; spur = 0;
        end else if (lat == 0) begin
          i_drv_rvalid = 1'b1; i_drv_rdata = pend; lat = -1;
        end else if (lat > 0) lat--;
        if (wr_taken) begin
          i_wr_valid = 1'b0; gap = 4; wr_taken = 0;
        end else if (!i_wr_valid && wr_q.size() > 0) begin
          if (gap > 0) gap--;
          else begin i_wr_valid = 1'b1; i_wr_data = wr_q[0]; end
        end
        if (bp_left > 0) begin
          bp_left--;
          if (bp_left == 0) i_drv_ready = 1'b1;
        end
      end
      #4;
      if (!rst_n) begin
        lat = -1; gap = 0; wr_taken = 0; bp_left = 0;
        i_drv_ready = 1'b1; i_drv_rvalid = 1'b0; i_wr_valid = 1'b0;
      end else begin
        if (o_rd_valid) begin
          rd_cnt++; checks++;
          if (exp_rd.size() == 0) begin
            fails++; $display("FAIL rd_data: unexpected o_rd_valid with %h, none required", o_rd_data);
          end else begin
            e = exp_rd.pop_front();
            if (o_rd_data !== e) begin
              fails++; $display("FAIL rd_data: got %h, required %h", o_rd_data, e);
            end
          end
        end
        if (o_done) begin done_cnt++; t_done = $time; busy_at_done = o_busy; end
        if (i_wr_valid && o_wr_ready) begin
          wr_hs++; wr_taken = 1; void'(wr_q.pop_front());
        end
        if (!i_drv_ready && bp_left > 0) begin
          bp_checks++; checks++;
          if (o_drv_valid !== 1'b1 || o_drv_data !== bp_byte) begin
            fails++; $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                              o_drv_valid, o_drv_data, bp_byte);
          end
        end else if (bp_armed && o_drv_valid && o_drv_data == bp_byte) begin
          i_drv_ready = 1'b0; bp_left = 5; bp_armed = 0;
        end
        if (o_drv_valid && i_drv_ready) begin
          hs_cnt++; checks++;
          if (exp_drv.size() == 0) begin
            fails++; $display("FAIL drv_byte: unexpected byte %h, none required", o_drv_data);
          end else begin
            e = exp_drv.pop_front();
            if (o_drv_data !== e) begin
              fails++; $display("FAIL drv_byte: got %h, required %h", o_drv_data, e);
            end
          end
          pend = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h5A;
          lat = 2;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [7:0] cmd, input bit ha, input logic [23:0] a,
                       input int wl, input int rl, output time t_acc);
    int n;
    n = 0;
    i_op_valid = 1'b1; i_op_cmd = cmd; i_op_has_addr = ha; i_op_addr = a;
    i_op_wr_len = LW'(wl); i_op_rd_len = LW'(rl);
    while (!o_op_ready && n < 400) begin tick(); n++; end
    t_acc = o_op_ready ? $time : 0;
    tick();
    i_op_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    int n;
    n = 0;
    while (done_cnt == base && n < 400) begin tick(); n++; end
    ok = (done_cnt != base);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({o_op_ready, o_wr_ready, o_drv_valid, o_drv_data, o_rd_valid, o_rd_data, o_busy, o_done}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_outputs: rdy=%b wrr=%b dv=%b dd=%h rv=%b rd=%h busy=%b done=%b, required 1 0 0 00 0 00 0 0",
                        o_op_ready, o_wr_ready, o_drv_valid, o_drv_data, o_rd_valid, o_rd_data, o_busy, o_done);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_read_status();
    int r0, d0; time ta; bit ok;
    r0 = rd_cnt; d0 = done_cnt;
    exp_drv.push_back(8'h05); exp_drv.push_back(8'h00);
    resp_q.push_back(8'hEE); resp_q.push_back(8'hA5);
    exp_rd.push_back(8'hA5);
    issue(8'h05, 0, 24'h0, 0, 1, ta);
    wait_done(d0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rdsr_done: no o_done within bound"); end
    checks++; if (busy_at_done !== 1'b1) begin fails++; $display("FAIL rdsr_busy_in_done: got %b, required 1", busy_at_done); end
    checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rdsr_busy_after: got %b, required 0", o_busy); end
    repeat (3) tick();
    checks++; if (rd_cnt - r0 != 1) begin fails++; $display("FAIL rdsr_rd_count: got %0d, required 1", rd_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL rdsr_done_count: got %0d, required 1", done_cnt - d0); end
    checks++; if (exp_drv.size() != 0) begin fails++; $display("FAIL rdsr_bytes_left: %0d bytes not sent, required 0", exp_drv.size()); end
  endtask

  task automatic test_read();
    int r0, d0; time ta; bit ok;
    logic [7:0] b[6];
    r0 = rd_cnt; d0 = done_cnt;
    b = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    foreach (b[i]) exp_drv.push_back(b[i]);
    for (int i = 0; i < 4; i++) resp_q.push_back(8'hEE);
    resp_q.push_back(8'hDE); resp_q.push_back(8'hAD);
    exp_rd.push_back(8'hDE); exp_rd.push_back(8'hAD);
    issue(8'h03, 1, 24'h123456, 0, 2, ta);
    wait_done(d0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL read_done: no o_done within bound"); end
    repeat (3) tick();
    checks++; if (rd_cnt - r0 != 2) begin fails++; $display("FAIL read_rd_count: got %0d, required 2", rd_cnt - r0); end
    checks++; if (exp_drv.size() != 0) begin fails++; $display("FAIL read_bytes_left: %0d bytes not sent, required 0", exp_drv.size()); end
  endtask

  task automatic test_page_program();
    int r0, d0, w0; time ta; bit ok;
    logic [7:0] b[7];
    r0 = rd_cnt; d0 = done_cnt; w0 = wr_hs;
    b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (b[i]) begin exp_drv.push_back(b[i]); resp_q.push_back(8'hEE); end
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    issue(8'h02, 1, 24'h000100, 3, 0, ta);
    wait_done(d0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL pp_done: no o_done within bound"); end
    repeat (3) tick();
    checks++; if (wr_hs - w0 != 3) begin fails++; $display("FAIL pp_wr_count: got %0d, required 3", wr_hs - w0); end
    checks++; if (rd_cnt != r0) begin fails++; $display("FAIL pp_no_rd: got %0d rd pulses, required 0", rd_cnt - r0); end
    checks++; if (exp_drv.size() != 0) begin fails++; $display("FAIL pp_bytes_left: %0d bytes not sent, required 0", exp_drv.size()); end
  endtask

  task automatic test_back_to_back();
    int d0, h0; time ta1, ta2, td; bit ok;
    d0 = done_cnt; h0 = hs_cnt;
    exp_drv.push_back(8'h06); exp_drv.push_back(8'h04);
    issue(8'h06, 0, 24'h0, 0, 0, ta1);
    issue(8'h04, 0, 24'h0, 0, 0, ta2);
    td = t_done;
    checks++; if (hs_cnt - h0 != 1) begin fails++; $display("FAIL b2b_first_bytes: got %0d bytes before second accept, required 1", hs_cnt - h0); end
    checks++;
    if (done_cnt - d0 != 1 || ta2 <= td || ta2 - td >= 10) begin
      fails++; $display("FAIL b2b_accept: second accepted at %0t, first done at %0t (dones=%0d), required accept in cycle after done",
                        ta2, td, done_cnt - d0);
    end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL b2b_done: second o_done missing"); end
    repeat (2) tick();
    checks++; if (exp_drv.size() != 0) begin fails++; $display("FAIL b2b_bytes_left: %0d bytes not sent, required 0", exp_drv.size()); end
  endtask

  task automatic test_backpressure();
    int d0, c0; time ta; bit ok;
    logic [7:0] b[5];
    d0 = done_cnt; c0 = bp_checks;
    b = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00};
    foreach (b[i]) exp_drv.push_back(b[i]);
    for (int i = 0; i < 4; i++) resp_q.push_back(8'hEE);
    resp_q.push_back(8'hC3); exp_rd.push_back(8'hC3);
    bp_byte = 8'h34; bp_armed = 1;
    issue(8'h03, 1, 24'h123456, 0, 1, ta);
    wait_done(d0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_done: no o_done within bound"); end
    repeat (2) tick();
    checks++; if (bp_checks - c0 != 4) begin fails++; $display("FAIL bp_stall_cycles: got %0d held samples, required 4", bp_checks - c0); end
    checks++; if (exp_drv.size() != 0 || exp_rd.size() != 0) begin
      fails++; $display("FAIL bp_left: drv=%0d rd=%0d outstanding, required 0 0", exp_drv.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset_mid();
    int h0, r0, d0; time ta; bit ok;
    logic [7:0] b[5];
    h0 = hs_cnt;
    b = '{8'h0B, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    foreach (b[i]) exp_drv.push_back(b[i]);
    issue(8'h0B, 1, 24'hABCDEF, 0, 1, ta);
    for (int n = 0; n < 100 && hs_cnt - h0 < 3; n++) tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_op_ready, o_wr_ready, o_drv_valid, o_drv_data, o_rd_valid, o_rd_data, o_busy, o_done}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++; $display("FAIL midrst_outputs: rdy=%b wrr=%b dv=%b dd=%h rv=%b rd=%h busy=%b done=%b, required 1 0 0 00 0 00 0 0",
                        o_op_ready, o_wr_ready, o_drv_valid, o_drv_data, o_rd_valid, o_rd_data, o_busy, o_done);
    end
    exp_drv.delete(); resp_q.delete(); exp_rd.delete(); wr_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    r0 = rd_cnt;
    spur = 1;
    repeat (4) tick();
    checks++; if (rd_cnt != r0 || o_busy !== 1'b0 || o_op_ready !== 1'b1) begin
      fails++; $display("FAIL spurious_rvalid: rd=%0d busy=%b ready=%b, required 0 0 1", rd_cnt - r0, o_busy, o_op_ready);
    end
    d0 = done_cnt;
    b = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    foreach (b[i]) exp_drv.push_back(b[i]);
    exp_drv.push_back(8'h00);
    for (int i = 0; i < 4; i++) resp_q.push_back(8'hEE);
    resp_q.push_back(8'h3C); resp_q.push_back(8'h4D);
    exp_rd.push_back(8'h3C); exp_rd.push_back(8'h4D);
    issue(8'h03, 1, 24'h000010, 0, 2, ta);
    wait_done(d0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL midrst_done: no o_done within bound"); end
    repeat (2) tick();
    checks++; if (rd_cnt - r0 != 2) begin fails++; $display("FAIL midrst_rd_count: got %0d, required 2", rd_cnt - r0); end
    checks++; if (exp_drv.size() != 0) begin fails++; $display("FAIL midrst_bytes_left: %0d bytes not sent, required 0", exp_drv.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_op_valid = 1'b0; i_op_cmd = 8'h00; i_op_has_addr = 1'b0; i_op_addr = 24'h0;
    i_op_wr_len = '0; i_op_rd_len = '0;
    test_reset();
    test_read_status();
    test_read();
    test_page_program();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_cmd_seq.md
Name: spi_flash_cmd_seq

Overview:
- Transaction sequencer that sits directly upstream of the byte-level SPI driver (spi_driver).
- Takes one flash-style request (opcode, optional 24-bit address, N write bytes, M read bytes) and breaks it into single bytes on the driver's valid/ready byte interface.
- Forwards the bytes captured during the read phase to the user and signals completion.
- Exactly one byte is outstanding at the driver at any time.

Parameters:
P_LEN_W, 16, width of the write-length and read-length fields
P_DUMMY, 8'h00, byte sent on MOSI during the read phase

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
i_op_valid  input  1  request valid
o_op_ready  output  1  request accepted when high together with i_op_valid
i_op_cmd  input  8  opcode byte
i_op_has_addr  input  1  1 = send 3 address bytes
i_op_addr  input  24  address, sent MSB byte first
i_op_wr_len  input  P_LEN_W  number of write-data bytes (0 allowed)
i_op_rd_len  input  P_LEN_W  number of read bytes (0 allowed)
i_wr_data  input  8  write-data stream byte
i_wr_valid  input  1  write-data stream valid
o_wr_ready  output  1  write byte consumed when high together with i_wr_valid
o_drv_data  output  8  byte to driver
o_drv_valid  output  1  byte valid to driver
i_drv_ready  input  1  driver ready
i_drv_rdata  input  8  byte received by driver
i_drv_rvalid  input  1  driver byte-complete pulse
o_rd_data  output  8  read byte to user
o_rd_valid  output  1  1-cycle pulse; no backpressure
o_busy  output  1  high whenever state != IDLE
o_done  output  1  1-cycle pulse at end of transaction

Behaviour:
- States: IDLE, CMD, ADDR, WDATA, RDATA, DONE.
- Internal `wait` flag: set when a driver handshake occurs (o_drv_valid & i_drv_ready); cleared on i_drv_rvalid.
- While `wait` = 1: o_drv_valid = 0 and o_wr_ready = 0.
- i_drv_rvalid while `wait` = 0 is ignored.
- IDLE:
  - o_op_ready = 1.
  - On accept, latch all request fields and enter CMD next cycle.
- CMD: o_drv_data = cmd, o_drv_valid = 1. After the byte completes:
  - has_addr = 1 → ADDR.
  - else wr_len ≠ 0 → WDATA.
  - else rd_len ≠ 0 → RDATA.
  - else → DONE.
- ADDR:
  - Sends addr[23:16], then [15:8], then [7:0], using a 2-bit byte index.
  - After the third byte completes, apply the same wr/rd/DONE selection as CMD.
- WDATA:
  - Pass-through: o_drv_data = i_wr_data; o_drv_valid = i_wr_valid & !wait; o_wr_ready = i_drv_ready & !wait.
  - Gaps in i_wr_valid stall the phase with no timeout.
  - After wr_len completions: rd_len ≠ 0 → RDATA, else → DONE.
- RDATA:
  - Sends P_DUMMY bytes.
  - On each i_drv_rvalid: o_rd_data = i_drv_rdata and o_rd_valid = 1 on the next cycle (registered).
  - After rd_len completions → DONE.
- DONE: o_done = 1 for one cycle → IDLE. A new request may be accepted the cycle after DONE.
- Byte holding: o_drv_data and o_drv_valid stay stable while o_drv_valid = 1 and i_drv_ready = 0.
- Counters:
  - P_LEN_W-bit down-counters, loaded from the latched lengths.
  - A phase is exited when its counter reaches 0 after a completion; no wrap-around.
- Byte-complete events in CMD, ADDR and WDATA are discarded and never reach o_rd_*.
- Requests presented while busy: o_op_ready = 0; the request is held off, not dropped.
- Reset (any time, including mid-transaction):
  - Return to IDLE; clear `wait` and all counters.
  - o_op_ready = 1, o_wr_ready = 0, o_drv_valid = 0, o_drv_data = 0, o_rd_valid = 0, o_rd_data = 0, o_busy = 0, o_done = 0.

Test Plan:
1. Read status: cmd 0x05, has_addr 0, wr 0, rd 1; driver model returns 0xA5 on byte 2 → driver sees 0x05, 0x00; exactly one o_rd_valid with 0xA5; o_done once; o_busy falls with DONE exit.
2. Read: cmd 0x03, addr 0x123456, rd 2; model returns 0xDE, 0xAD → driver bytes 03, 12, 34, 56, 00, 00; o_rd outputs DE then AD only; no o_rd_valid during cmd/addr.
3. Page program: cmd 0x02, addr 0x000100, wr 3, data 11, 22, 33 with 4-cycle i_wr_valid gaps → driver bytes 02, 00, 01, 00, 11, 22, 33; o_wr_ready pulses exactly 3 times; no o_rd_valid.
4. Write enable: cmd 0x06, no addr, wr 0, rd 0 → single byte 0x06, then o_done; second request back-to-back is accepted only after DONE.
5. Backpressure: hold i_drv_ready low 5 cycles in ADDR → o_drv_data stays 0x34 and o_drv_valid stays 1 throughout; sequence resumes correctly.
6. Reset asserted after the second address byte, then a new read request → all outputs at reset values; new transaction restarts from CMD with fresh counts; spurious i_drv_rvalid in IDLE is ignored.
